ram_burst_ctrl: RTL and testbench

RAM_BURST_CTRL -- requirements
Module: ram_burst_ctrl

---
 rtl/ram_burst_ctrl_pkg.sv | 16 +
 rtl/ram_burst_ctrl.sv | 134 +++++++++++++
 tb/tb_ram_burst_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_burst_ctrl_pkg.sv
// Shared types and sizing for the RAM burst controller.
// Holds the FSM state enum, default widths and RAM depth.
package ram_burst_ctrl_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 8;
  localparam int RAM_DEPTH  = 1 << ADDR_W_DEF;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    RD_ADDR,
    RD_HOLD
  } state_t;

endpackage

// File: rtl/ram_burst_ctrl.sv
// Burst controller: turns addr/len commands into RAM beats.
// Ports: cmd_* command handshake, wr_* write beats, rd_* read
// beats, mem_* single-port RAM side, busy (not IDLE), err
// (rejected command pulse).
// Option: RAM_BURST_CTRL_BOUNDS_EN rejects bursts that would
// run past the top address instead of wrapping.
module ram_burst_ctrl
  import ram_burst_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              err
);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] beats_left;
  logic [DATA_W-1:0] rd_q;
  logic              cmd_fire;
  logic              bad_cmd;
  logic              beat_done;
  logic              last_beat;

  assign cmd_ready = (state == IDLE);
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign wr_ready  = (state == WRITE);
  assign mem_we    = wr_ready & wr_valid;
  assign mem_addr  = cur_addr;
  assign mem_wdata = mem_we ? wr_data : '0;
  assign rd_valid  = (state == RD_HOLD);
  assign rd_data   = rd_q;
  assign busy      = (state != IDLE);
  assign beat_done = mem_we | (rd_valid & rd_ready);
  assign last_beat = (beats_left == '0);

`ifdef RAM_BURST_CTRL_BOUNDS_EN
  logic [ADDR_W:0] span;
  logic            err_q;

  // Carry out of addr+len means the burst passes the top word.
  assign span    = {1'b0, cmd_addr} + {1'b0, cmd_len};
  assign bad_cmd = span[ADDR_W];
  assign err     = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= cmd_fire & bad_cmd;
    end
  end
`else
  assign bad_cmd = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (cmd_fire && !bad_cmd) begin
          state_nxt = cmd_write ? WRITE : RD_ADDR;
        end
      end
      WRITE: begin
        if (mem_we && last_beat) begin
          state_nxt = IDLE;
        end
      end
      RD_ADDR: begin
        state_nxt = RD_HOLD;
      end
      RD_HOLD: begin
        if (rd_ready) begin
          state_nxt = last_beat ? IDLE : RD_ADDR;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr   <= '0;
      beats_left <= '0;
      rd_q       <= '0;
    end else begin
      if (cmd_fire && !bad_cmd) begin
        cur_addr   <= cmd_addr;
        beats_left <= cmd_len;
      end else if (beat_done) begin
        cur_addr <= cur_addr + ADDR_W'(1);
        if (!last_beat) begin
          beats_left <= beats_left - ADDR_W'(1);
        end
      end
      // Address has been stable for the whole RD_ADDR cycle.
      if (state == RD_ADDR) begin
        rd_q <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed bench for ram_burst_ctrl with a 64x8 RAM model.
// Inputs change on the falling edge; checks follow #1 later.
module tb_ram_burst_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [5:0] cmd_addr;
  logic [5:0] cmd_len;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       mem_we;
  logic [5:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       busy;
  logic       err;

  logic [7:0] ram [64];

  int n_tests = 0;
  int n_fail  = 0;

  ram_burst_ctrl #(.ADDR_W(6), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = ram[mem_addr];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic issue(input logic w, input logic [5:0] a,
                       input logic [5:0] l);
    step();
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    #1;
    chk("cmd_ready_idle", cmd_ready, 1);
  endtask

  logic [7:0] wdat [4];
  logic [5:0] wadr [4];
  logic [7:0] exp0;

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 8'(i) ^ 8'h5A;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_len = '0; wr_valid = 1'b0;
    wr_data = 8'hAA; rd_ready = 1'b0;
    #3;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_err", err, 0);
    step();
    rst_n = 1'b1;

    // wr_valid while idle must not touch the RAM
    step();
    wr_valid = 1'b1;
    #1;
    chk("idle_wr_ready", wr_ready, 0);
    chk("idle_mem_we", mem_we, 0);
    wr_valid = 1'b0;

    // write 5..8
    wdat = '{8'h11, 8'h22, 8'h33, 8'h44};
    issue(1'b1, 6'd5, 6'd3);
    for (int i = 0; i < 4; i++) begin
      step();
      cmd_valid = 1'b0;
      wr_valid  = 1'b1;
      wr_data   = wdat[i];
      #1;
      chk("wr_we", mem_we, 1);
      chk("wr_addr", mem_addr, 5 + i);
      chk("wr_wdata", mem_wdata, wdat[i]);
      chk("wr_cmd_ready", cmd_ready, 0);
      chk("wr_busy", busy, 1);
    end
    step();
    wr_valid = 1'b0;
    #1;
    chk("wr_done_ready", cmd_ready, 1);
    chk("wr_done_busy", busy, 0);
    chk("wr_done_we", mem_we, 0);
    for (int i = 0; i < 4; i++) chk("wr_ram", ram[5 + i], wdat[i]);

    // read 5..8, rd_ready high: beats two cycles apart
    rd_ready = 1'b1;
    issue(1'b0, 6'd5, 6'd3);
    for (int i = 0; i < 4; i++) begin
      step();
      cmd_valid = 1'b0;
      #1;
      chk("rd_addr_valid", rd_valid, 0);
      chk("rd_addr", mem_addr, 5 + i);
      chk("rd_addr_we", mem_we, 0);
      step();
      #1;
      chk("rd_valid", rd_valid, 1);
      chk("rd_data", rd_data, wdat[i]);
    end
    step();
    #1;
    chk("rd_done_ready", cmd_ready, 1);
    chk("rd_done_valid", rd_valid, 0);

    // read 6..7 with rd_ready low for four cycles
    rd_ready = 1'b0;
    issue(1'b0, 6'd6, 6'd1);
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      #1;
      chk("stall_valid", rd_valid, 1);
      chk("stall_data", rd_data, 8'h22);
      chk("stall_we", mem_we, 0);
      chk("stall_addr", mem_addr, 6);
    end
    rd_ready = 1'b1;
    step();
    #1;
    chk("stall_next_valid", rd_valid, 0);
    chk("stall_next_addr", mem_addr, 7);
    step();
    #1;
    chk("stall_next_data", rd_data, 8'h33);
    step();
    #1;
    chk("stall_done_ready", cmd_ready, 1);

    // write 62 len 3: wraps or is rejected
    wdat = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    wadr = '{6'd62, 6'd63, 6'd0, 6'd1};
    issue(1'b1, 6'd62, 6'd3);
`ifdef RAM_BURST_CTRL_BOUNDS_EN
    step();
    cmd_valid = 1'b0;
    wr_valid  = 1'b1;
    wr_data   = 8'hA0;
    #1;
    chk("bnd_err", err, 1);
    chk("bnd_busy", busy, 0);
    chk("bnd_ready", cmd_ready, 1);
    chk("bnd_we", mem_we, 0);
    chk("bnd_wr_ready", wr_ready, 0);
    step();
    #1;
    chk("bnd_err_end", err, 0);
    chk("bnd_we_end", mem_we, 0);
    wr_valid = 1'b0;
    chk("bnd_ram62", ram[62], 8'(62) ^ 8'h5A);
    exp0 = 8'h5A;
`else
    for (int i = 0; i < 4; i++) begin
      step();
      cmd_valid = 1'b0;
      wr_valid  = 1'b1;
      wr_data   = wdat[i];
      #1;
      chk("wrap_we", mem_we, 1);
      chk("wrap_addr", mem_addr, wadr[i]);
      chk("wrap_err", err, 0);
      if (i == 0) begin
        step();
        wr_valid = 1'b0;
        #1;
        chk("wrap_stall_we", mem_we, 0);
        chk("wrap_stall_busy", busy, 1);
        chk("wrap_stall_addr", mem_addr, 63);
      end
    end
    step();
    wr_valid = 1'b0;
    #1;
    chk("wrap_done_ready", cmd_ready, 1);
    for (int i = 0; i < 4; i++) chk("wrap_ram", ram[wadr[i]], wdat[i]);
    exp0 = 8'hA2;
`endif

    // reset in the middle of a write at 10, len 7
    issue(1'b1, 6'd10, 6'd7);
    for (int i = 0; i < 2; i++) begin
      step();
      cmd_valid = 1'b0;
      wr_valid  = 1'b1;
      wr_data   = 8'h50 + 8'(i);
      #1;
      chk("mid_we", mem_we, 1);
    end
    step();
    wr_data = 8'h52;
    rst_n   = 1'b0;
    #1;
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_addr", mem_addr, 0);
    step();
    rst_n    = 1'b1;
    wr_valid = 1'b0;
    #1;
    chk("mid_ram10", ram[10], 8'h50);
    chk("mid_ram11", ram[11], 8'h51);
    chk("mid_ram12", ram[12], 8'h0C ^ 8'h5A);
    step();
    #1;
    chk("mid_after_busy", busy, 0);
    chk("mid_after_we", mem_we, 0);

    // fresh single-beat read at 0
    rd_ready = 1'b1;
    issue(1'b0, 6'd0, 6'd0);
    step();
    cmd_valid = 1'b0;
    #1;
    chk("post_addr", mem_addr, 0);
    step();
    #1;
    chk("post_valid", rd_valid, 1);
    chk("post_data", rd_data, exp0);
    step();
    #1;
    chk("post_ready", cmd_ready, 1);
    chk("post_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
